// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads 16-bit words from a synchronous
// instruction memory and offers them to the datapath over valid/ready.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [15:0]           mem_rdata,
    output logic [15:0]           instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic [15:0]           fetch_count
);

    // state | meaning
    // IDLE  | no read outstanding; waits for halt to drop
    // REQ   | read strobe issued for pc
    // CAPT  | memory data returning; latched into instr
    // HOLD  | instr offered to datapath until handshake
    typedef enum logic [1:0] {IDLE, REQ, CAPT, HOLD} state_t;

    state_t                  state;
    state_t                  nextState;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    handshake;
    logic                    loadInstr;
    logic                    advancePc;

    assign handshake = instr_valid & instr_ready;
    assign mem_addr  = pc;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        loadInstr = 1'b0;
        advancePc = 1'b0;
        mem_rd_en = 1'b0;
        case (state)
            IDLE: if (!halt) nextState = REQ;
            REQ: begin
                mem_rd_en = 1'b1;
                nextState = CAPT;
            end
            CAPT: begin
                loadInstr = 1'b1;
                nextState = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    advancePc = 1'b1;
                    nextState = halt ? IDLE : REQ;
                end
            end
            default: nextState = IDLE;
        endcase
        // A redirect squashes whatever is in flight or held and refetches.
        if (redirect) begin
            loadInstr = 1'b0;
            nextState = halt ? IDLE : REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            pc_out      <= RESET_PC;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            if (handshake && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;

            if (redirect)
                pc <= redirect_pc;
            else if (advancePc)
                pc <= pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

            if (redirect) begin
                instr_valid <= 1'b0;
            end else if (loadInstr) begin
                instr       <= mem_rdata;
                pc_out      <= pc;
                instr_valid <= 1'b1;
            end else if (handshake) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing scenarios followed by a
// randomized run checked against a transaction-level stream model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] memAddr, memRdata, instr, pcOut, redirectPc, fetchCount;
    logic        memRdEn, instrValid, instrReady, redirect, halt;

    logic [15:0] memAddr2, memRdata2, instr2, pcOut2, fetchCount2;
    logic        memRdEn2, instrValid2;
    logic        ready2 = 1'b1, halt2 = 1'b0, redirect2 = 1'b0;
    logic [15:0] redirectPc2 = 16'h0000;

    logic [15:0] mem [65536];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_addr(memAddr), .mem_rd_en(memRdEn),
        .mem_rdata(memRdata), .instr(instr), .instr_valid(instrValid),
        .instr_ready(instrReady), .pc_out(pcOut), .redirect(redirect),
        .redirect_pc(redirectPc), .halt(halt), .fetch_count(fetchCount)
    );

    instr_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFF)) dutWrap (
        .clk(clk), .reset(reset), .mem_addr(memAddr2), .mem_rd_en(memRdEn2),
        .mem_rdata(memRdata2), .instr(instr2), .instr_valid(instrValid2),
        .instr_ready(ready2), .pc_out(pcOut2), .redirect(redirect2),
        .redirect_pc(redirectPc2), .halt(halt2), .fetch_count(fetchCount2)
    );

    // Synchronous memory: data one cycle after the strobe.
    always @(posedge clk) begin
        if (memRdEn)  memRdata  <= mem[memAddr];
        if (memRdEn2) memRdata2 <= mem[memAddr2];
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset;
        reset = 1'b1; redirect = 1'b0; halt = 1'b0; redirectPc = 16'h0000;
        tick;
        tick;
    endtask

    logic [15:0] rdSeen, vSeen;
    logic [15:0] expPc, prevInstr, prevPcOut;
    int          expCount;
    logic        prevHalt, prevHold, hs;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0125; mem[1] = 16'h5301; mem[2] = 16'h0A32;
        mem[3] = 16'h1234; mem[4] = 16'hBEEF;
        instrReady = 1'b1;

        // Reset values and basic 3-cycle cadence
        applyReset;
        checkVal("rst_valid",  32'(instrValid), 32'd0);
        checkVal("rst_rden",   32'(memRdEn),    32'd0);
        checkVal("rst_count",  32'(fetchCount), 32'd0);
        checkVal("rst_instr",  32'(instr),      32'd0);
        checkVal("rst_addr",   32'(memAddr),    32'd0);
        checkVal("rst_pcout",  32'(pcOut),      32'd0);
        checkVal("rst_addr_w", 32'(memAddr2),   32'hFFFF);
        reset = 1'b0;
        rdSeen = '0; vSeen = '0;
        for (int c = 1; c <= 10; c++) begin
            tick;
            rdSeen[c] = memRdEn;
            vSeen[c]  = instrValid;
            if (instrValid) begin
                checkVal("seq_instr", 32'(instr), 32'(mem[c/3-1]));
                checkVal("seq_pcout", 32'(pcOut), 32'(c/3-1));
            end
            if (c == 3 || c == 6) begin
                checkVal("wrap_valid", 32'(instrValid2), 32'd1);
                checkVal("wrap_pcout", 32'(pcOut2), (c == 3) ? 32'hFFFF : 32'h0000);
                checkVal("wrap_instr", 32'(instr2), (c == 3) ? 32'(mem[16'hFFFF]) : 32'(mem[0]));
            end
        end
        checkVal("seq_rden_cycles",  32'(rdSeen), 32'h0492);
        checkVal("seq_valid_cycles", 32'(vSeen),  32'h0248);
        checkVal("seq_count",        32'(fetchCount), 32'd3);

        // Back-pressure: held word must not move
        instrReady = 1'b0;
        applyReset;
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c >= 3 && c <= 7) begin
                checkVal("bp_valid", 32'(instrValid), 32'd1);
                checkVal("bp_instr", 32'(instr), 32'h0125);
                checkVal("bp_pcout", 32'(pcOut), 32'd0);
                checkVal("bp_rden",  32'(memRdEn), 32'd0);
                checkVal("bp_count", 32'(fetchCount), 32'd0);
                if (c == 7) instrReady = 1'b1;
            end
            if (c == 8) checkVal("bp_count_after", 32'(fetchCount), 32'd1);
        end

        // Redirect during CAPT of address 1
        instrReady = 1'b1;
        applyReset;
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c == 5) begin
                redirect = 1'b1; redirectPc = 16'h0040;
            end
            if (c == 6) begin
                redirect = 1'b0;
                checkVal("rdc_rden",  32'(memRdEn), 32'd1);
                checkVal("rdc_addr",  32'(memAddr), 32'h0040);
                checkVal("rdc_valid", 32'(instrValid), 32'd0);
            end
            if (c == 7) checkVal("rdc_valid_capt", 32'(instrValid), 32'd0);
            if (c == 8) begin
                checkVal("rdc_pcout", 32'(pcOut), 32'h0040);
                checkVal("rdc_instr", 32'(instr), 32'(mem[16'h0040]));
            end
        end

        // Redirect coincident with handshake at pc=5
        applyReset;
        reset = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            tick;
            if (c == 18) begin
                checkVal("rhs_pcout", 32'(pcOut), 32'd5);
                checkVal("rhs_count_before", 32'(fetchCount), 32'd5);
                redirect = 1'b1; redirectPc = 16'h0010;
            end
            if (c == 19) begin
                redirect = 1'b0;
                checkVal("rhs_count_after", 32'(fetchCount), 32'd6);
                checkVal("rhs_addr", 32'(memAddr), 32'h0010);
                checkVal("rhs_rden", 32'(memRdEn), 32'd1);
            end
        end

        // Halt during REQ of pc=3, then reset mid-CAPT
        applyReset;
        reset = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            tick;
            if (c == 10) begin
                checkVal("hlt_req_addr", 32'(memAddr), 32'd3);
                halt = 1'b1;
            end
            if (c == 12) begin
                checkVal("hlt_valid", 32'(instrValid), 32'd1);
                checkVal("hlt_pcout", 32'(pcOut), 32'd3);
                checkVal("hlt_instr", 32'(instr), 32'h1234);
            end
            if (c >= 13 && c <= 17) begin
                checkVal("hlt_rden", 32'(memRdEn), 32'd0);
                checkVal("hlt_addr", 32'(memAddr), 32'd4);
                if (c == 17) halt = 1'b0;
            end
            if (c == 18) begin
                checkVal("hlt_resume_rden", 32'(memRdEn), 32'd1);
                checkVal("hlt_resume_addr", 32'(memAddr), 32'd4);
            end
            if (c == 19) reset = 1'b1;
            if (c == 20) begin
                checkVal("mrst_valid", 32'(instrValid), 32'd0);
                checkVal("mrst_addr",  32'(memAddr), 32'd0);
                checkVal("mrst_rden",  32'(memRdEn), 32'd0);
                reset = 1'b0;
            end
            if (c == 21) checkVal("mrst_rden_again", 32'(memRdEn), 32'd1);
            if (c == 23) begin
                checkVal("mrst_instr", 32'(instr), 32'h0125);
                checkVal("mrst_pcout", 32'(pcOut), 32'd0);
            end
        end

        // Randomized run against an in-order stream model
        instrReady = 1'b0;
        applyReset;
        reset = 1'b0;
        expPc = 16'h0000; expCount = 0;
        prevHalt = 1'b1; prevHold = 1'b0;
        prevInstr = '0; prevPcOut = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            checkVal("rnd_addr",  32'(memAddr), 32'(expPc));
            checkVal("rnd_count", 32'(fetchCount), 32'(expCount));
            if (memRdEn) checkVal("rnd_rden_while_halted", 32'(prevHalt), 32'd0);
            if (prevHold) begin
                checkVal("rnd_hold_valid", 32'(instrValid), 32'd1);
                checkVal("rnd_hold_instr", 32'(instr), 32'(prevInstr));
                checkVal("rnd_hold_pcout", 32'(pcOut), 32'(prevPcOut));
            end
            if (instrValid) begin
                checkVal("rnd_pcout", 32'(pcOut), 32'(expPc));
                checkVal("rnd_instr", 32'(instr), 32'(mem[expPc]));
            end

            instrReady = ($urandom_range(0, 9) < 7);
            halt       = ($urandom_range(0, 19) < 3);
            redirect   = ($urandom_range(0, 19) == 0);
            redirectPc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);

            hs = instrValid & instrReady;
            if (hs) begin
                expPc = expPc + 16'd1;
                if (expCount < 65535) expCount++;
            end
            if (redirect) expPc = redirectPc;
            prevHalt  = halt;
            prevHold  = instrValid & ~hs & ~redirect;
            prevInstr = instr;
            prevPcOut = pcOut;
        end
        checkVal("rnd_progress", 32'(expCount > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the register-file/ALU datapath.
- Holds the program counter and reads 16-bit CR16A instruction words from a synchronous instruction memory.
- Presents each word to the datapath through a valid/ready handshake.
- Accepts PC redirects for branches and jumps, and a halt request.
- Replaces the datapath's direct instruction feed.

Parameters:
ADDR_WIDTH, 16, width of PC and memory word address (word-addressed, one instruction per word)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
mem_addr  output  ADDR_WIDTH  instruction memory word address; always equals current pc
mem_rd_en  output  1  memory read strobe; data returns on mem_rdata one cycle later
mem_rdata  input  16  memory read data, valid the cycle after mem_rd_en
instr  output  16  held instruction word for the datapath
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  datapath accepts instr this cycle
pc_out  output  ADDR_WIDTH  address from which the held instr was fetched
redirect  input  1  load redirect_pc and squash the in-flight or held instruction
redirect_pc  input  ADDR_WIDTH  branch/jump target
halt  input  1  suppress new memory requests while high
fetch_count  output  16  number of accepted instructions, saturating

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE, pc=RESET_PC, pc_out=RESET_PC
  - instr=16'h0000, instr_valid=0, mem_rd_en=0, fetch_count=0
- States: IDLE, REQ, CAPT, HOLD. mem_rd_en is a decode of state REQ only.
- IDLE: go to REQ if halt=0, otherwise stay.
- REQ: mem_rd_en=1, mem_addr=pc; go to CAPT.
- CAPT:
  - Register instr<=mem_rdata, pc_out<=pc, instr_valid<=1; go to HOLD.
  - First-instruction latency: instr_valid rises 3 cycles after reset deasserts with halt=0.
- HOLD:
  - instr, pc_out and instr_valid stay stable until the handshake.
  - Handshake = instr_valid & instr_ready.
  - On handshake: instr_valid<=0, pc<=pc+1, fetch_count increments; go to IDLE if halt=1, else REQ.
  - Peak throughput is one instruction per 3 cycles.
- PC arithmetic: pc+1 modulo 2^ADDR_WIDTH; all-ones wraps to 0 with no error.
- fetch_count saturates at 16'hFFFF and holds.
- Redirect (any non-reset state, priority over normal transitions):
  - pc<=redirect_pc, instr_valid<=0, next state REQ, or IDLE if halt=1.
  - In CAPT, the returning mem_rdata is discarded and instr is not updated.
  - In REQ, the issued read is ignored; its data is never captured.
  - Redirect in the same cycle as a handshake: the handshake still counts (fetch_count increments) but pc takes redirect_pc, not pc+1.
- Halt:
  - Sampled only in IDLE and on leaving HOLD.
  - An already-issued read completes and its instruction is held and offered normally.
  - While halted: mem_rd_en=0 and pc is frozen except by redirect.
- instr_ready while instr_valid=0 has no effect.
- Reset mid-fetch: any pending read data is discarded; restart from RESET_PC.

Test Plan:
- Reset then release, halt=0, instr_ready=1, memory[0..2]=16'h0125,16'h5301,16'h0A32 → mem_rd_en pulses at cycles 1,4,7; instr_valid high at cycles 3,6,9 with instr 0125/5301/0A32 and pc_out 0,1,2; fetch_count=3.
- instr_ready=0 for 5 cycles after first valid → instr=16'h0125 and pc_out=0 stable, no further mem_rd_en, fetch_count=0 until ready rises.
- redirect=1, redirect_pc=16'h0040 during CAPT of address 1 → mem_rdata discarded, instr_valid stays 0, next mem_rd_en with mem_addr=16'h0040, delivered pc_out=16'h0040.
- Redirect and handshake in same HOLD cycle at pc=5, redirect_pc=16'h0010 → fetch_count increments by 1, next mem_addr=16'h0010.
- RESET_PC=16'hFFFF, ready=1 → first pc_out=16'hFFFF, second pc_out=16'h0000.
- halt asserted in REQ at pc=3 → instruction 3 still delivered, then mem_rd_en=0 until halt drops; reset asserted mid-CAPT → instr_valid=0, pc=RESET_PC next cycle.
